// File: rtl/wasm_pkg.sv
// Shared types for the WebAssembly load/store path: memory op kinds, trap codes
// and the LSU state encoding.
package wasm_pkg;

  typedef enum logic [3:0] {
    MEM_NOP        = 4'd0,
    MEM_LOAD_I32   = 4'd1,
    MEM_LOAD_I64   = 4'd2,
    MEM_LOAD_I8_S  = 4'd3,
    MEM_LOAD_I8_U  = 4'd4,
    MEM_LOAD_I16_S = 4'd5,
    MEM_LOAD_I16_U = 4'd6,
    MEM_LOAD_I32_S = 4'd7,
    MEM_LOAD_I32_U = 4'd8,
    MEM_STORE_I8   = 4'd9,
    MEM_STORE_I16  = 4'd10,
    MEM_STORE_I32  = 4'd11,
    MEM_STORE_I64  = 4'd12
  } mem_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE          = 2'd0,
    TRAP_OUT_OF_BOUNDS = 2'd1,
    TRAP_UNREACHABLE   = 2'd2
  } trap_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op >= MEM_LOAD_I32) && (op <= MEM_LOAD_I32_U);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op >= MEM_STORE_I8) && (op <= MEM_STORE_I64);
  endfunction

endpackage

// File: rtl/wasm_lsu_perf.sv
// Saturating access counters for the LSU; only instantiated when
// WASM_LSU_PERF_EN is defined.
module wasm_lsu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_load,
  input  logic        inc_store,
  input  logic        inc_trap,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_traps
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_traps  <= '0;
    end else begin
      perf_loads  <= sat_inc(perf_loads, inc_load);
      perf_stores <= sat_inc(perf_stores, inc_store);
      perf_traps  <= sat_inc(perf_traps, inc_trap);
    end
  end

endmodule

// File: rtl/wasm_lsu.sv
// Load/store unit between the execute stage and linear memory: EA add, bounds
// overflow trap, one-shot memory issue and store-commit timeout.
// Optional perf counters are enabled with the WASM_LSU_PERF_EN macro.
module wasm_lsu
  import wasm_pkg::*;
#(
  parameter int WR_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_op_t     req_op,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output trap_t       resp_trap,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_addr,
  output mem_op_t     mem_rd_op,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output mem_op_t     mem_wr_op,
  output logic [63:0] mem_wr_data,
  input  logic        mem_wr_valid,
  input  trap_t       mem_trap
`ifdef WASM_LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_traps
`endif
);

  localparam int CNT_W = (WR_TIMEOUT < 2) ? 1 : $clog2(WR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      resp_data_q, resp_data_d;
  trap_t            resp_trap_q, resp_trap_d;

  mem_op_t          op_p1;
  logic [31:0]      ea_p1;
  logic [63:0]      wdata_p1;

  // Carry out of bit 31 means the address wrapped past 4 GiB.
  logic [32:0]      ea_sum;
  assign ea_sum = {1'b0, req_base} + {1'b0, req_offset};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_trap_d = resp_trap_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_rd_op   = MEM_NOP;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_op   = MEM_NOP;
    mem_wr_data = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (ea_sum[32]) begin
            state_d     = RESP;
            resp_data_d = '0;
            resp_trap_d = TRAP_OUT_OF_BOUNDS;
          end else if (is_load(req_op) || is_store(req_op)) begin
            state_d = ISSUE;
          end else begin
            state_d     = RESP;
            resp_data_d = '0;
            resp_trap_d = TRAP_NONE;
          end
        end
      end

      ISSUE: begin
        cnt_d = '0;
        if (is_load(op_p1)) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = ea_p1;
          mem_rd_op   = op_p1;
          state_d     = RESP;
          if (mem_rd_valid) begin
            resp_data_d = mem_rd_data;
            resp_trap_d = TRAP_NONE;
          end else begin
            resp_data_d = '0;
            resp_trap_d = mem_trap;
          end
        end else if (is_store(op_p1)) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = ea_p1;
          mem_wr_op   = op_p1;
          mem_wr_data = wdata_p1;
          resp_data_d = '0;
          if (mem_trap != TRAP_NONE) begin
            state_d     = RESP;
            resp_trap_d = mem_trap;
          end else begin
            state_d = WAIT_WR;
          end
        end else begin
          state_d     = RESP;
          resp_data_d = '0;
          resp_trap_d = TRAP_NONE;
        end
      end

      WAIT_WR: begin
        if (mem_wr_valid) begin
          state_d     = RESP;
          resp_trap_d = TRAP_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          resp_trap_d = TRAP_OUT_OF_BOUNDS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_trap_q <= TRAP_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_trap_q <= resp_trap_d;
    end
  end

  // Request capture: operands are only meaningful once state leaves IDLE.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_p1    <= req_op;
      ea_p1    <= ea_sum[31:0];
      wdata_p1 <= req_wdata;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_trap = resp_trap_q;

`ifdef WASM_LSU_PERF_EN
  logic resp_entry, inc_load, inc_store, inc_trap;

  always_comb begin
    resp_entry = (state_q != RESP) && (state_d == RESP);
    inc_trap   = resp_entry && (resp_trap_d != TRAP_NONE);
    inc_load   = resp_entry && !inc_trap && (state_q == ISSUE) && is_load(op_p1);
    inc_store  = resp_entry && !inc_trap && (state_q == WAIT_WR);
  end

  wasm_lsu_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .inc_load    (inc_load),
    .inc_store   (inc_store),
    .inc_trap    (inc_trap),
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_traps  (perf_traps)
  );
`endif

endmodule

// File: tb/tb_wasm_lsu.sv
// Scoreboard bench for wasm_lsu: a one-page byte-array memory answers the LSU,
// an abstract model predicts each response and a monitor pops and compares.
`timescale 1ns/1ps
module tb_wasm_lsu;
  import wasm_pkg::*;

  localparam int WR_TIMEOUT = 4;
  localparam int MEM_BYTES  = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_op_t     req_op = MEM_NOP;
  logic [31:0] req_base = '0;
  logic [31:0] req_offset = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_data;
  trap_t       resp_trap;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  mem_op_t     mem_rd_op;
  logic [63:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  mem_op_t     mem_wr_op;
  logic [63:0] mem_wr_data;
  logic        mem_wr_valid = 1'b0;
  trap_t       mem_trap;
`ifdef WASM_LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_traps;
`endif

  wasm_lsu #(.WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_trap    (resp_trap),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_op    (mem_rd_op),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_op    (mem_wr_op),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_trap     (mem_trap)
`ifdef WASM_LSU_PERF_EN
    ,
    .perf_loads   (perf_loads),
    .perf_stores  (perf_stores),
    .perf_traps   (perf_traps)
`endif
  );

  typedef struct {
    logic [63:0] data;
    trap_t       trap;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          en_seen = 0;
  int          rdy_mode = 0;
  int          exp_loads = 0, exp_stores = 0, exp_traps = 0;
  bit          drop_wr = 1'b0;
  bit          seeded = 1'b0;
  logic [31:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic [63:0] last_data = '0;
  trap_t       last_trap = TRAP_NONE;
  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];

  function automatic int nbytes(input mem_op_t op);
    case (op)
      MEM_LOAD_I8_S, MEM_LOAD_I8_U, MEM_STORE_I8:                    return 1;
      MEM_LOAD_I16_S, MEM_LOAD_I16_U, MEM_STORE_I16:                 return 2;
      MEM_LOAD_I32, MEM_LOAD_I32_S, MEM_LOAD_I32_U, MEM_STORE_I32:   return 4;
      MEM_LOAD_I64, MEM_STORE_I64:                                   return 8;
      default:                                                       return 0;
    endcase
  endfunction

  function automatic bit is_st(input mem_op_t op);
    return op inside {MEM_STORE_I8, MEM_STORE_I16, MEM_STORE_I32, MEM_STORE_I64};
  endfunction

  function automatic bit fits(input longint unsigned ea, input int n);
    return (ea + longint'(n)) <= longint'(MEM_BYTES);
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input mem_op_t op);
    case (op)
      MEM_LOAD_I8_S:  return {{56{raw[7]}}, raw[7:0]};
      MEM_LOAD_I8_U:  return {56'd0, raw[7:0]};
      MEM_LOAD_I16_S: return {{48{raw[15]}}, raw[15:0]};
      MEM_LOAD_I16_U: return {48'd0, raw[15:0]};
      MEM_LOAD_I32_S: return {{32{raw[31]}}, raw[31:0]};
      MEM_LOAD_I32, MEM_LOAD_I32_U: return {32'd0, raw[31:0]};
      default:        return raw;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 131) ^ (i >> 7) ^ 8'h5A);
  endfunction

  // Memory fixture: combinational read/bounds trap, registered write commit.
  always @* begin
    logic [63:0] raw;
    raw          = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    mem_trap     = TRAP_NONE;
    if (mem_rd_en) begin
      if (fits(64'(mem_rd_addr), nbytes(mem_rd_op))) begin
        for (int i = 0; i < 8; i++)
          if (i < nbytes(mem_rd_op)) raw[8*i +: 8] = mem[int'(mem_rd_addr) + i];
        mem_rd_valid = 1'b1;
        mem_rd_data  = extend(raw, mem_rd_op);
      end else begin
        mem_trap = TRAP_OUT_OF_BOUNDS;
      end
    end
    if (mem_wr_en && !fits(64'(mem_wr_addr), nbytes(mem_wr_op))) mem_trap = TRAP_OUT_OF_BOUNDS;
  end

  always @(posedge clk) begin
    mem_wr_valid <= 1'b0;
    if (!seeded) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= pat(i);
      seeded <= 1'b1;
    end else if (mem_wr_en) begin
      last_wr_addr <= mem_wr_addr;
      last_wr_data <= mem_wr_data;
      if (fits(64'(mem_wr_addr), nbytes(mem_wr_op)) && !drop_wr) begin
        for (int i = 0; i < 8; i++)
          if (i < nbytes(mem_wr_op)) mem[int'(mem_wr_addr) + i] <= mem_wr_data[8*i +: 8];
        mem_wr_valid <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: expected outcome straight from the access rules.
  task automatic model(input mem_op_t op, input logic [31:0] b, input logic [31:0] o,
                       input logic [63:0] w, input bit drop, output exp_t e);
    longint unsigned ea;
    int n;
    logic [63:0] raw;
    ea     = 64'(b) + 64'(o);
    n      = nbytes(op);
    e.data = '0;
    e.trap = TRAP_NONE;
    e.lat  = 1;
    e.acc  = 0;
    if (ea >= 64'h1_0000_0000) begin
      e.trap = TRAP_OUT_OF_BOUNDS;
      exp_traps++;
    end else if (n == 0) begin
      e.lat = 1;
    end else if (is_st(op)) begin
      e.lat = 2;
      if (!fits(ea, n)) begin
        e.trap = TRAP_OUT_OF_BOUNDS;
        exp_traps++;
      end else if (drop) begin
        e.lat  = 2 + WR_TIMEOUT;
        e.trap = TRAP_OUT_OF_BOUNDS;
        exp_traps++;
      end else begin
        e.lat = 3;
        for (int i = 0; i < n; i++) ref_mem[int'(ea) + i] = w[8*i +: 8];
        exp_stores++;
      end
    end else begin
      e.lat = 2;
      if (!fits(ea, n)) begin
        e.trap = TRAP_OUT_OF_BOUNDS;
        exp_traps++;
      end else begin
        raw = '0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[int'(ea) + i];
        e.data = extend(raw, op);
        exp_loads++;
      end
    end
  endtask

  task automatic wait_resp(input int want);
    for (int n = 0; n < 40 && done_cnt < want; n++) @(negedge clk);
    chk("resp_done", 64'(done_cnt >= want), 64'd1);
  endtask

  task automatic issue(input mem_op_t op, input logic [31:0] b, input logic [31:0] o,
                       input logic [63:0] w, input bit drop, input bit track, input bit wait_done);
    exp_t e;
    bit got;
    int want;
    want = done_cnt + 1;
    @(posedge clk); #1;
    drop_wr    = drop;
    req_op     = op;
    req_base   = b;
    req_offset = o;
    req_wdata  = w;
    req_valid  = 1'b1;
    got        = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_accepted", 64'(got), 64'd1);
    if (got && track) begin
      model(op, b, o, w, drop, e);
      e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wait_done && track && got) wait_resp(want);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(0, 2) != 0);
      default: resp_ready = 1'b0;
    endcase
  end

  // Monitor: pops on the first cycle of each response, then checks it is held.
  initial begin
    exp_t cur;
    bit holding;
    bit have_cur;
    holding  = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en) en_seen++;
      chk("rd_wr_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
      if (rst) begin
        holding = 1'b0;
      end else if (resp_valid) begin
        if (!holding) begin
          chk("sb_pending", 64'(sbq.size() != 0), 64'd1);
          have_cur = (sbq.size() != 0);
          if (have_cur) begin
            cur = sbq.pop_front();
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            chk("resp_data", resp_data, cur.data);
            chk("resp_trap", 64'(resp_trap), 64'(cur.trap));
          end
          last_data = resp_data;
          last_trap = resp_trap;
          holding   = 1'b1;
        end else begin
          if (have_cur) begin
            chk("hold_data", resp_data, cur.data);
            chk("hold_trap", 64'(resp_trap), 64'(cur.trap));
          end
          chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        if (resp_ready) begin
          holding = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int en0;
    int want;
    mem_op_t op;
    logic [31:0] b, o;
    int sel;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pat(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_trap", 64'(resp_trap), 64'(TRAP_NONE));
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_mem_wr_data", mem_wr_data, 64'd0);
`ifdef WASM_LSU_PERF_EN
    chk("rst_perf_loads", 64'(perf_loads), 64'd0);
    chk("rst_perf_stores", 64'(perf_stores), 64'd0);
    chk("rst_perf_traps", 64'(perf_traps), 64'd0);
`endif

    en0 = en_seen;
    issue(MEM_STORE_I32, 32'h100, 32'h4, 64'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    chk("st_en_cycles", 64'(en_seen - en0), 64'd1);
    chk("st_wr_addr", 64'(last_wr_addr), 64'h104);
    chk("st_wr_data", last_wr_data, 64'hDEADBEEF);
    chk("st_trap", 64'(last_trap), 64'(TRAP_NONE));

    en0 = en_seen;
    issue(MEM_LOAD_I8_S, 32'h107, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);
    chk("ld_en_cycles", 64'(en_seen - en0), 64'd1);
    chk("ld_i8s_data", last_data, 64'hFFFF_FFFF_FFFF_FFDE);
    chk("ld_i8s_trap", 64'(last_trap), 64'(TRAP_NONE));

    en0 = en_seen;
    issue(MEM_LOAD_I32, 32'hFFFF_FFF0, 32'h20, 64'h0, 1'b0, 1'b1, 1'b1);
    issue(MEM_STORE_I64, 32'hFFFF_FFF0, 32'h20, 64'h1234, 1'b0, 1'b1, 1'b1);
    chk("ovf_no_enables", 64'(en_seen - en0), 64'd0);
    chk("ovf_trap", 64'(last_trap), 64'(TRAP_OUT_OF_BOUNDS));

    issue(MEM_LOAD_I64, 32'hFFFC, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);
    chk("oob_ld_trap", 64'(last_trap), 64'(TRAP_OUT_OF_BOUNDS));
    chk("oob_ld_data", last_data, 64'd0);

    issue(MEM_STORE_I64, 32'h200, 32'h8, 64'hCAFE_F00D_0123_4567, 1'b1, 1'b1, 1'b1);
    chk("st_timeout_trap", 64'(last_trap), 64'(TRAP_OUT_OF_BOUNDS));
    issue(MEM_NOP, 32'h10, 32'h10, 64'h0, 1'b0, 1'b1, 1'b1);
    chk("nop_trap", 64'(last_trap), 64'(TRAP_NONE));

    // Backpressure: response held while a second request waits.
    rdy_mode = 2;
    want = done_cnt + 1;
    issue(MEM_LOAD_I32, 32'h104, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 10 && !resp_valid; n++) @(negedge clk);
    chk("stall_resp_seen", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    req_op    = MEM_LOAD_I64;
    req_base  = 32'h0;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", 64'(resp_valid), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_data", resp_data, 64'hDEADBEEF);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy_mode  = 0;
    wait_resp(want);

    // Reset while a store waits for its commit.
    issue(MEM_STORE_I32, 32'h300, 32'h0, 64'h55AA, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("waitwr_no_en", 64'(mem_wr_en | mem_rd_en), 64'd0);
    chk("waitwr_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    drop_wr = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
`ifdef WASM_LSU_PERF_EN
    chk("abort_perf_loads", 64'(perf_loads), 64'd0);
    chk("abort_perf_stores", 64'(perf_stores), 64'd0);
    chk("abort_perf_traps", 64'(perf_traps), 64'd0);
`endif
    exp_loads  = 0;
    exp_stores = 0;
    exp_traps  = 0;

    rdy_mode = 1;
    for (int t = 0; t < 80; t++) begin
      op  = mem_op_t'(4'($urandom_range(0, 12)));
      sel = $urandom_range(0, 7);
      if (sel <= 4) begin
        b = $urandom_range(0, 32'hFFFF);
        o = $urandom_range(0, 31);
      end else if (sel == 5) begin
        b = 32'hFFF0 + $urandom_range(0, 15);
        o = $urandom_range(0, 15);
      end else if (sel == 6) begin
        b = $urandom;
        o = $urandom;
      end else begin
        b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        o = 32'h10 + $urandom_range(0, 31);
      end
      issue(op, b, o, {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'b1, 1'b1);
    end
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
`ifdef WASM_LSU_PERF_EN
    chk("perf_loads", 64'(perf_loads), 64'(exp_loads));
    chk("perf_stores", 64'(perf_stores), 64'(exp_stores));
    chk("perf_traps", 64'(perf_traps), 64'(exp_traps));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
